// File: rtl/regfile_fwd_sb.sv
// General-purpose register file with a priority forwarding network, a per-register
// scoreboard for long-latency writers, and optional HI/LO storage (REGFILE_HILO_EN).
module regfile_fwd_sb #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NFWD = 3,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*DW-1:0]    rd_data,
  output logic                 rd_stall,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD-1:0]      fwd_ready,
  input  logic [NFWD*AW-1:0]   fwd_addr,
  input  logic [NFWD*DW-1:0]   fwd_data,
  input  logic                 wb_we,
  input  logic [AW-1:0]        wb_addr,
  input  logic [DW-1:0]        wb_data,
  input  logic                 mc_issue,
  input  logic [AW-1:0]        mc_addr,
  input  logic                 flush,
  output logic                 sb_busy,
  input  logic                 hi_we,
  input  logic                 lo_we,
  input  logic [DW-1:0]        hi_wdata,
  input  logic [DW-1:0]        lo_wdata,
  input  logic [NFWD-1:0]      hi_fwd_we,
  input  logic [NFWD-1:0]      lo_fwd_we,
  input  logic [NFWD*DW-1:0]   hi_fwd_data,
  input  logic [NFWD*DW-1:0]   lo_fwd_data,
  output logic [DW-1:0]        hi_rdata,
  output logic [DW-1:0]        lo_rdata
);

  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [NREG-1:0] pending_q, pending_d;

  // Next-state for storage and scoreboard.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    regs_d    = regs_q;
    pending_d = pending_q;
    if (wb_we && wb_addr != '0) regs_d[wb_addr] = wb_data;
    if (flush) begin
      pending_d = '0;
    end else begin
      if (wb_we) pending_d[wb_addr] = 1'b0;
      // A younger long-latency op to the same register keeps it pending.
      if (mc_issue && mc_addr != '0) pending_d[mc_addr] = 1'b1;
    end
  end

  // NOTE: the register array is reset explicitly because reads must return 0 after reset;
  // this costs a reset on every storage flop instead of using a RAM macro.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
      pending_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  assign sb_busy = |pending_q;

  logic [AW-1:0]  rd_a;
  logic           rd_hit;
  logic [DW-1:0]  rd_val;
  logic           rd_stl;
  logic [NRD-1:0] port_stall;

  // Per-port resolution: youngest forwarding source, then write-through, then storage.
  always_comb begin
    rd_data    = '0;
    port_stall = '0;
    rd_a       = '0;
    rd_hit     = 1'b0;
    rd_val     = '0;
    rd_stl     = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      rd_a   = rd_addr[p*AW +: AW];
      rd_hit = 1'b0;
      rd_val = '0;
      rd_stl = 1'b0;
      if (rd_a != '0) begin
        for (int i = 0; i < NFWD; i++) begin
          if (!rd_hit && fwd_we[i] && fwd_addr[i*AW +: AW] == rd_a) begin
            rd_hit = 1'b1;
            rd_val = fwd_data[i*DW +: DW];
            rd_stl = !fwd_ready[i];
          end
        end
        if (!rd_hit) begin
          if (wb_we && wb_addr == rd_a) rd_val = wb_data;
          else if (pending_q[rd_a])     rd_stl = 1'b1;
          else                          rd_val = regs_q[rd_a];
        end
      end
      rd_data[p*DW +: DW] = rd_val;
      port_stall[p]       = rd_stl;
    end
  end

  assign rd_stall = |port_stall;

`ifdef REGFILE_HILO_EN
  logic [DW-1:0] hi_q, hi_d, lo_q, lo_d;
  logic          hi_hit, lo_hit;

  always_comb begin
    hi_d = hi_we ? hi_wdata : hi_q;
    lo_d = lo_we ? lo_wdata : lo_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_comb begin
    hi_hit   = 1'b0;
    lo_hit   = 1'b0;
    hi_rdata = hi_we ? hi_wdata : hi_q;
    lo_rdata = lo_we ? lo_wdata : lo_q;
    for (int i = 0; i < NFWD; i++) begin
      if (!hi_hit && hi_fwd_we[i]) begin
        hi_hit   = 1'b1;
        hi_rdata = hi_fwd_data[i*DW +: DW];
      end
      if (!lo_hit && lo_fwd_we[i]) begin
        lo_hit   = 1'b1;
        lo_rdata = lo_fwd_data[i*DW +: DW];
      end
    end
  end
`else
  // HI/LO not built: inputs are deliberately sunk and outputs read as zero.
  logic unused_hilo;
  assign unused_hilo = ^{hi_we, lo_we, hi_wdata, lo_wdata,
                         hi_fwd_we, lo_fwd_we, hi_fwd_data, lo_fwd_data};
  assign hi_rdata = '0;
  assign lo_rdata = '0;
`endif

endmodule

// File: tb/tb_regfile_fwd_sb.sv
// Scoreboard bench for regfile_fwd_sb: stimulus pushes model predictions, a negedge
// monitor pops and compares them against the DUT.
module tb_regfile_fwd_sb;
  localparam int DW = 32, NREG = 32, NRD = 2, NFWD = 3, AW = 5;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [NRD*AW-1:0]  rd_addr;
  logic [NRD*DW-1:0]  rd_data;
  logic               rd_stall;
  logic [NFWD-1:0]    fwd_we, fwd_ready;
  logic [NFWD*AW-1:0] fwd_addr;
  logic [NFWD*DW-1:0] fwd_data;
  logic               wb_we;
  logic [AW-1:0]      wb_addr;
  logic [DW-1:0]      wb_data;
  logic               mc_issue;
  logic [AW-1:0]      mc_addr;
  logic               flush;
  logic               sb_busy;
  logic               hi_we, lo_we;
  logic [DW-1:0]      hi_wdata, lo_wdata;
  logic [NFWD-1:0]    hi_fwd_we, lo_fwd_we;
  logic [NFWD*DW-1:0] hi_fwd_data, lo_fwd_data;
  logic [DW-1:0]      hi_rdata, lo_rdata;

  regfile_fwd_sb #(.DW(DW), .NREG(NREG), .NRD(NRD), .NFWD(NFWD)) dut (
    .clk(clk), .resetn(resetn), .rd_addr(rd_addr), .rd_data(rd_data), .rd_stall(rd_stall),
    .fwd_we(fwd_we), .fwd_ready(fwd_ready), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .mc_issue(mc_issue),
    .mc_addr(mc_addr), .flush(flush), .sb_busy(sb_busy), .hi_we(hi_we), .lo_we(lo_we),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata), .hi_fwd_we(hi_fwd_we), .lo_fwd_we(lo_fwd_we),
    .hi_fwd_data(hi_fwd_data), .lo_fwd_data(lo_fwd_data), .hi_rdata(hi_rdata),
    .lo_rdata(lo_rdata)
  );

  typedef struct {
    string         name;
    logic [DW-1:0] d0, d1;
    bit            dv0, dv1;
    bit            stall;
    bit            busy;
    logic [DW-1:0] hi, lo;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Architectural reference state.
  logic [DW-1:0] m_regs [NREG];
  bit            m_pend [NREG];
  logic [DW-1:0] m_hi, m_lo;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, req);
  endtask

  function automatic void model_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                                     output bit st, output bit dv);
    d = '0; st = 1'b0; dv = 1'b1;
    if (a == '0) return;
    for (int i = 0; i < NFWD; i++) begin
      if (fwd_we[i] && fwd_addr[i*AW +: AW] == a) begin
        if (fwd_ready[i]) d = fwd_data[i*DW +: DW];
        else begin st = 1'b1; dv = 1'b0; end
        return;
      end
    end
    if (wb_we && wb_addr == a) begin d = wb_data; return; end
    if (m_pend[a]) begin st = 1'b1; dv = 1'b0; return; end
    d = m_regs[a];
  endfunction

  function automatic logic [DW-1:0] model_hilo(input logic [NFWD-1:0] fwe,
      input logic [NFWD*DW-1:0] fd, input logic we, input logic [DW-1:0] wd,
      input logic [DW-1:0] stored);
`ifdef REGFILE_HILO_EN
    for (int i = 0; i < NFWD; i++) if (fwe[i]) return fd[i*DW +: DW];
    if (we) return wd;
    return stored;
`else
    return '0;
`endif
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin m_regs[r] = '0; m_pend[r] = 1'b0; end
    m_hi = '0; m_lo = '0;
  endtask

  task automatic model_update();
    if (!resetn) return;
    if (wb_we && wb_addr != '0) m_regs[wb_addr] = wb_data;
    if (hi_we) m_hi = hi_wdata;
    if (lo_we) m_lo = lo_wdata;
    if (flush) begin
      for (int r = 0; r < NREG; r++) m_pend[r] = 1'b0;
    end else begin
      if (wb_we) m_pend[wb_addr] = 1'b0;
      if (mc_issue && mc_addr != '0) m_pend[mc_addr] = 1'b1;
    end
  endtask

  task automatic push_exp(input string name);
    exp_t e;
    bit   st0, st1;
    e.name = name;
    model_read(rd_addr[0 +: AW], e.d0, st0, e.dv0);
    model_read(rd_addr[AW +: AW], e.d1, st1, e.dv1);
    e.stall = st0 | st1;
    e.busy  = 1'b0;
    for (int r = 0; r < NREG; r++) if (m_pend[r]) e.busy = 1'b1;
    e.hi = model_hilo(hi_fwd_we, hi_fwd_data, hi_we, hi_wdata, m_hi);
    e.lo = model_hilo(lo_fwd_we, lo_fwd_data, lo_we, lo_wdata, m_lo);
    exp_q.push_back(e);
  endtask

  // Inputs are held from posedge+1 through the next posedge; the monitor samples at negedge.
  task automatic cycle(input string name);
    push_exp(name);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rd_addr = '0; fwd_we = '0; fwd_ready = '0; fwd_addr = '0; fwd_data = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0; mc_issue = 1'b0; mc_addr = '0; flush = 1'b0;
    hi_we = 1'b0; lo_we = 1'b0; hi_wdata = '0; lo_wdata = '0;
    hi_fwd_we = '0; lo_fwd_we = '0; hi_fwd_data = '0; lo_fwd_data = '0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.dv0) check({e.name, " rd0"}, rd_data[0 +: DW], e.d0);
        if (e.dv1) check({e.name, " rd1"}, rd_data[DW +: DW], e.d1);
        check({e.name, " stall"}, {31'b0, rd_stall}, {31'b0, e.stall});
        check({e.name, " busy"}, {31'b0, sb_busy}, {31'b0, e.busy});
        check({e.name, " hi"}, hi_rdata, e.hi);
        check({e.name, " lo"}, lo_rdata, e.lo);
      end
    end
  end

  initial begin : stimulus
    idle();
    model_reset();
    resetn = 1'b0;
    @(posedge clk); #1;
    cycle("reset");
    resetn = 1'b1;

    // Forwarding priority.
    fwd_we = 3'b111; fwd_ready = 3'b111; fwd_addr = {5'd5, 5'd5, 5'd5};
    fwd_data = {32'hC, 32'hB, 32'hA}; rd_addr = {5'd0, 5'd5};
    cycle("prio_ex");
    fwd_we = 3'b110;
    cycle("prio_mem");

    // Load-use stall then ready.
    idle();
    fwd_we = 3'b001; fwd_addr = {10'd0, 5'd7}; fwd_ready = 3'b000; rd_addr = {5'd7, 5'd0};
    cycle("lu_stall");
    fwd_ready = 3'b001; fwd_data = {64'd0, 32'h55};
    cycle("lu_ready");

    // Scoreboard set and write-through clear.
    idle(); mc_issue = 1'b1; mc_addr = 5'd9;
    cycle("mc9_issue");
    idle(); rd_addr = {5'd0, 5'd9};
    cycle("r9_stall");
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h1234;
    cycle("r9_wb");
    idle(); rd_addr = {5'd0, 5'd9};
    cycle("r9_done");

    // Set/clear collision, then flush (also overriding a same-cycle issue).
    idle(); mc_issue = 1'b1; mc_addr = 5'd4; wb_we = 1'b1; wb_addr = 5'd4; wb_data = 32'h4444;
    cycle("coll");
    idle(); rd_addr = {5'd4, 5'd4};
    cycle("coll_pend");
    flush = 1'b1; mc_issue = 1'b1; mc_addr = 5'd6;
    cycle("flush");
    idle(); rd_addr = {5'd6, 5'd4};
    cycle("after_flush");

    // Register 0 is immune to writes and issues.
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF; mc_issue = 1'b1; mc_addr = 5'd0;
    cycle("r0_write");
    idle();
    cycle("r0_after");

    // HI/LO write, forward, fallback.
    hi_we = 1'b1; hi_wdata = 32'h11; lo_we = 1'b1; lo_wdata = 32'h77;
    cycle("hi_write");
    idle(); hi_fwd_we = 3'b010; hi_fwd_data = {32'h0, 32'h22, 32'h0};
    cycle("hi_fwd");
    idle();
    cycle("hi_store");

    // Randomized traffic on a small register window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      idle();
      for (int p = 0; p < NRD; p++) rd_addr[p*AW +: AW] = AW'($urandom_range(0, 7));
      for (int i = 0; i < NFWD; i++) begin
        fwd_we[i]             = ($urandom_range(0, 3) == 0);
        fwd_ready[i]          = ($urandom_range(0, 3) != 0);
        fwd_addr[i*AW +: AW]  = AW'($urandom_range(0, 7));
        fwd_data[i*DW +: DW]  = $urandom;
        hi_fwd_we[i]          = ($urandom_range(0, 5) == 0);
        lo_fwd_we[i]          = ($urandom_range(0, 5) == 0);
        hi_fwd_data[i*DW +: DW] = $urandom;
        lo_fwd_data[i*DW +: DW] = $urandom;
      end
      wb_we    = ($urandom_range(0, 1) == 0);
      wb_addr  = AW'($urandom_range(0, 7));
      wb_data  = $urandom;
      mc_issue = ($urandom_range(0, 4) == 0);
      mc_addr  = AW'($urandom_range(0, 7));
      flush    = ($urandom_range(0, 30) == 0);
      hi_we    = ($urandom_range(0, 3) == 0);
      lo_we    = ($urandom_range(0, 3) == 0);
      hi_wdata = $urandom;
      lo_wdata = $urandom;
      cycle("rand");
    end

    // Reset mid-operation drops pending state immediately.
    idle(); mc_issue = 1'b1; mc_addr = 5'd3;
    cycle("pre_reset");
    idle(); rd_addr = {5'd3, 5'd3};
    resetn = 1'b0;
    model_reset();
    cycle("mid_reset");
    resetn = 1'b1;
    cycle("post_reset");

    idle();
    repeat (4) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d queued expectations, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_fwd_sb.md
# regfile_fwd_sb

Parametrised successor to the pipeline's general-purpose register file, with HI/LO, a generalised forwarding network and a per-register scoreboard for long-latency writers (divider, cache-miss loads). It sits in ID and serves NRD combinational read ports. Each read resolves, in priority order, through NFWD in-flight pipeline sources, same-cycle write-back, then storage. It raises `rd_stall` when a read depends on data that is not yet available.

## Interface
- `DW`, 32, data width.
- `NREG`, 32, register count; `AW = $clog2(NREG)`; register 0 hardwired to zero.
- `NRD`, 2, number of read ports.
- `NFWD`, 3, forwarding sources; index 0 = youngest (EX), highest priority.
- `clk`  in  1  rising-edge clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `rd_addr`  in  NRD*AW  read addresses, port p at `[p*AW +: AW]`.
- `rd_data`  out  NRD*DW  resolved read data.
- `rd_stall`  out  1  any read port depends on unready data.
- `fwd_we`, `fwd_ready`  in  NFWD each  source will write / its data is valid now.
- `fwd_addr`, `fwd_data`  in  NFWD*AW, NFWD*DW  source destination and data.
- `wb_we`, `wb_addr`, `wb_data`  in  1, AW, DW  architectural write port.
- `mc_issue`, `mc_addr`  in  1, AW  long-latency op issued, target register.
- `flush`  in  1  discard all pending scoreboard entries.
- `sb_busy`  out  1  OR of all pending bits (registered).
- `hi_we`, `lo_we`, `hi_wdata`, `lo_wdata`  in  1, 1, DW, DW  HI/LO write.
- `hi_fwd_we`, `lo_fwd_we`, `hi_fwd_data`, `lo_fwd_data`  in  NFWD, NFWD, NFWD*DW, NFWD*DW  HI/LO forwarding.
- `hi_rdata`, `lo_rdata`  out  DW each  resolved HI/LO.

## Operation
- Storage: `NREG×DW` array, `pending[NREG]`, `hi`, `lo`. All are cleared by reset.
- Write: at posedge, if `wb_we && wb_addr!=0`, then `array[wb_addr] <= wb_data`. HI/LO are written the same way.
- Read resolution for port p, with `a = rd_addr[p]`:
  - `a==0` → 0, no stall.
  - Else the lowest i with `fwd_we[i] && fwd_addr[i]==a` wins. It returns `fwd_data[i]` if `fwd_ready[i]`; otherwise it asserts a stall and the data value is don't-care. Lower-priority matches are ignored.
  - Else if `wb_we && wb_addr==a` → `wb_data` (write-through).
  - Else if `pending[a]` → stall.
  - Else `array[a]`.
- HI/LO resolution: lowest i with `hi_fwd_we[i]` → `hi_fwd_data[i]`; else `hi_we` → `hi_wdata`; else `hi`. LO is identical. HI/LO never stall.
- `rd_stall` is the OR over ports of the per-port stall.
- Scoreboard update at posedge:
  - `mc_issue && mc_addr!=0` sets `pending[mc_addr]`.
  - `wb_we` clears `pending[wb_addr]`.
  - Same register, same cycle: set wins, because the new op is younger.
  - `flush` clears every bit and overrides `mc_issue` in the same cycle.
  - Writes to register 0 never set pending.

## Timing
- Reads, `rd_stall`, `hi_rdata` and `lo_rdata` are purely combinational from inputs and state; there is no added latency.
- Array, HI/LO and pending updates become visible one cycle after the edge. The same-cycle effect of a write is delivered only by the write-through path.
- A pending bit set at edge N stalls reads of that register from cycle N+1 until the cycle of the clearing `wb_we` write, which write-through serves.
- Reset outputs: `rd_data`=0, `hi_rdata`=`lo_rdata`=0 (with all write/forward inputs idle), `rd_stall`=0, `sb_busy`=0.
- Reset asserted mid-operation clears all pending bits immediately; an in-flight long-latency op is then untracked.

## Configuration
- Macro `REGFILE_HILO_EN`.
- Defined: HI/LO storage and forwarding as described.
- Undefined: no HI/LO registers are built. The ports remain, inputs are ignored, and `hi_rdata`/`lo_rdata` are tied to 0.

## Test plan
- Priority: `fwd_we`=3'b111, all `fwd_addr`=5, ready, data 0xA/0xB/0xC; `rd_addr0`=5 → 0xA, no stall. Then clear `fwd_we[0]` → 0xB.
- Load-use: `fwd_we[0]`=1, `fwd_addr[0]`=7, `fwd_ready[0]`=0, `rd_addr1`=7 → `rd_stall`=1. Raise ready with data 0x55 → stall=0, data 0x55.
- Scoreboard: `mc_issue` on r9 → from next cycle, read r9 gives stall=1 and `sb_busy`=1. `wb_we` r9=0x1234 → same cycle data 0x1234, stall=0. Following cycle `sb_busy`=0.
- Set/clear collision: `mc_issue` r4 with `wb_we` r4 in the same cycle → next cycle r4 is still pending. `flush` → stall drops next cycle.
- Register 0: `wb_we` r0=0xFFFF and `mc_issue` r0 → read r0 returns 0, stall=0, `sb_busy`=0.
- HI/LO: `hi_we` 0x11 at edge, then `hi_fwd_we[1]`=1 with 0x22 → 0x22. Drop forward → 0x11. Without `REGFILE_HILO_EN` → 0 throughout.
